// File: rtl/mux_nx1_seq.sv
// mux_nx1_seq: N:1 data selector with registered output and valid/ready
// handshake, for the FFT datapath.
// Manual mode forwards one selected channel per input beat; auto mode
// latches the whole bundle and emits it one channel per output beat,
// channel 0 first.
// Optional feature: define MUX_SEQ_LAST_EN to add the out_last port, which
// marks the final beat of a bundle (every beat in manual mode).
module mux_nx1_seq #(
    parameter int data_width = 16,
    parameter int num_ch     = 4,
    parameter int sel_width  = $clog2(num_ch)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [num_ch*data_width-1:0] in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         mode,
    input  logic [sel_width-1:0]         sel,
    output logic [data_width-1:0]        out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
`ifdef MUX_SEQ_LAST_EN
    output logic                         out_last,
`endif
    output logic [sel_width-1:0]         ch_idx
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAN  = 2'd1,
        SER  = 2'd2
    } state_t;

    localparam logic [sel_width-1:0] LAST_IDX = sel_width'(num_ch - 1);

    state_t                         state;
    logic [num_ch*data_width-1:0]   bundle;
    logic [sel_width-1:0]           cnt;
    logic [sel_width-1:0]           nxt_idx;
    logic [data_width-1:0]          man_data;
    logic [data_width-1:0]          ser_data;
    logic                           accept;
    logic                           xfer;

    assign accept  = in_valid & in_ready;
    assign xfer    = out_valid & out_ready;
    assign nxt_idx = cnt + 1'b1;

    // Ready depends on state: manual mode gets full throughput, auto mode
    // only takes a new bundle as the last channel of the current one leaves.
    always_comb begin
        in_ready = 1'b0;
        case (state)
            IDLE:    in_ready = 1'b1;
            MAN:     in_ready = ~out_valid | out_ready;
            SER:     in_ready = (cnt == LAST_IDX) & out_ready;
            default: in_ready = 1'b0;
        endcase
    end

    // Manual channel select; an out-of-range sel matches no channel and yields zero.
    always_comb begin
        man_data = '0;
        for (int k = 0; k < num_ch; k++) begin
            if (sel == sel_width'(k)) begin
                man_data = in_data[k*data_width +: data_width];
            end
        end
    end

    // Next channel of the latched bundle for the serialiser.
    always_comb begin
        ser_data = '0;
        for (int k = 0; k < num_ch; k++) begin
            if (nxt_idx == sel_width'(k)) begin
                ser_data = bundle[k*data_width +: data_width];
            end
        end
    end

    // Control FSM with registered output stage; an accept always wins over
    // a plain transfer so back-to-back beats and bundles never bubble.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            bundle    <= '0;
            cnt       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            ch_idx    <= '0;
`ifdef MUX_SEQ_LAST_EN
            out_last  <= 1'b0;
`endif
        end else if (accept) begin
            out_valid <= 1'b1;
            if (!mode) begin
                state    <= MAN;
                out_data <= man_data;
                ch_idx   <= sel;
`ifdef MUX_SEQ_LAST_EN
                out_last <= 1'b1;
`endif
            end else begin
                state    <= SER;
                bundle   <= in_data;
                cnt      <= '0;
                out_data <= in_data[data_width-1:0];
                ch_idx   <= '0;
`ifdef MUX_SEQ_LAST_EN
                out_last <= 1'b0;
`endif
            end
        end else if (xfer) begin
            if (state == SER && cnt != LAST_IDX) begin
                cnt      <= nxt_idx;
                out_data <= ser_data;
                ch_idx   <= nxt_idx;
`ifdef MUX_SEQ_LAST_EN
                out_last <= (nxt_idx == LAST_IDX);
`endif
            end else begin
                state     <= IDLE;
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/mux_nx1_seq.md
Name: mux_nx1_seq

Overview:
- Parametrised N:1 data selector for the FFT datapath, with a registered output and a valid/ready handshake.
- Two modes, chosen per input beat:
  - Manual: one selected channel per input beat.
  - Auto: the whole N-channel bundle is latched and emitted one channel per output beat, channel 0 first. This feeds butterfly stages serially.
- Sits between the input/stage buffers and the butterfly/twiddle units.

Parameters:
- data_width, 16, bits per channel.
- num_ch, 4, number of input channels; minimum 2.
- sel_width, $clog2(num_ch), width of sel and ch_idx.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_data  input  num_ch*data_width  flat bus; channel k occupies bits [k*data_width +: data_width].
- in_valid  input  1  in_data, mode and sel are valid.
- in_ready  output  1  block accepts an input beat this cycle.
- mode  input  1  0 = manual select, 1 = auto serialise.
- sel  input  sel_width  channel index, manual mode only.
- out_data  output  data_width  selected channel data, registered.
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accepts out_data.
- ch_idx  output  sel_width  channel index of the current out_data.

Behaviour:
- Single clock domain; reset is synchronous and active-low, sampled on the rising edge of clk.
- Reset values:
  - out_data = 0, out_valid = 0, ch_idx = 0.
  - FSM = IDLE, bundle register = 0, counter = 0.
  - in_ready = 1 in the first cycle after reset release.
- Handshakes:
  - Input accept = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
  - out_data, out_valid and ch_idx hold stable while out_valid = 1 and out_ready = 0.
- mode and sel are sampled only at input accept; changes at any other time are ignored.
- FSM states: IDLE, MAN, SER.
- IDLE:
  - in_ready = 1.
  - On accept with mode = 0 -> MAN.
  - On accept with mode = 1 -> SER.
- MAN (manual):
  - On accept, out_data <= channel sel, ch_idx <= sel, out_valid <= 1. Latency is 1 cycle.
  - If sel >= num_ch, out_data <= 0, ch_idx <= sel, out_valid still 1.
  - in_ready = ~out_valid | out_ready, giving full throughput with back-to-back beats.
  - On a transfer with no new accept, out_valid <= 0 and FSM -> IDLE.
  - A new accept in the same cycle as a transfer replaces the output; the next mode decides the next state.
- SER (auto):
  - On accept, the full in_data is latched into the bundle register, out_data <= channel 0, ch_idx <= 0, out_valid <= 1, counter <= 0.
  - Each transfer advances the counter and presents the next channel the following cycle.
  - in_ready = 1 only when counter = num_ch-1 and out_ready = 1.
  - Accept on the last transfer -> back-to-back bundle with no bubble; state follows the new mode.
  - Last transfer with no accept -> out_valid <= 0, IDLE.
  - Throughput: one bundle per num_ch cycles when out_ready is held high.
- Counter wraps from num_ch-1 to 0 only through a new accept; no wrap beyond the bundle.
- Reset mid-operation (any state) drops the pending bundle and partial output; no beat is emitted after reset.
- in_valid is ignored while in_ready = 0; there is no buffering beyond the one output register and one bundle register.

Optional Feature:
- Macro: MUX_SEQ_LAST_EN.
- Defined:
  - Adds port out_last (output, 1 bit, reset 0), registered with out_data.
  - SER mode: out_last = 1 on channel num_ch-1.
  - MAN mode: out_last = 1 on every beat.
  - Stable under backpressure like out_data.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan (data_width=4, num_ch=4, in_data channels = {8,7,6,5}, i.e. ch0=5 ... ch3=8):
- Reset: hold rst_n=0 for 2 clocks with in_valid=1 -> out_valid=0, out_data=0, ch_idx=0; after release, in_ready=1.
- Manual, out_ready=1: mode=0, sel=0,1,2,0 on consecutive cycles -> one cycle later out_data = 5,6,7,5, ch_idx = 0,1,2,0, no bubbles.
- Manual, out-of-range sel: num_ch=3 build, sel=3 -> out_data=0, out_valid=1, ch_idx=3.
- Auto, out_ready=1: mode=1, single accept -> out_data = 5,6,7,8 on 4 consecutive cycles, ch_idx 0..3.
  - in_ready=1 only in the 4th cycle.
  - Second bundle {4,3,2,1} accepted there -> 1,2,3,4 follow with no gap.
- Auto, backpressure: drop out_ready for 3 cycles while out_data=6 -> out_data=6 and ch_idx=1 held, in_ready=0; resume -> 7,8 follow.
  - With MUX_SEQ_LAST_EN defined: out_last=1 only with 8.
- Reset mid-SER: assert rst_n=0 while out_data=7 -> next cycle out_valid=0, and no 8 appears after release.
